alu_pipe_acc: RTL and testbench
===============================

// Module: alu_pipe_acc
// PURPOSE
//   Parametrised, registered successor to the team's 4-bit combinational ALU.
//   Uses the same 3-bit opcode map, widened to WIDTH bits, and adds status flags,
//   an internal accumulator and a valid/ready handshake on both sides.
//   Sits between an operand/opcode producer and a result consumer in the datapath.
//   One-cycle registered latency; holds its output under consumer backpressure.
// PARAMETERS
//   WIDTH  8  operand, result and accumulator width in bits (WIDTH >= 2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      A, B and op are valid this cycle
//   in_ready   out  1      block accepts the input this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   op         in   3      opcode (see BEHAVIOUR)
//   out_valid  out  1      result and flags are valid
//   out_ready  in   1      consumer accepts the result this cycle
//   alu_out    out  WIDTH  registered result
//   flag_c     out  1      carry-out (ADD/ACC) or borrow (SUB)
//   flag_z     out  1      alu_out == 0
//   flag_n     out  1      alu_out[WIDTH-1]
//   flag_v     out  1      signed two's-complement overflow
//   acc_out    out  WIDTH  current accumulator value
// BEHAVIOUR
// - Single clock domain, one clock (clk).
// - Reset is synchronous and active-high (rst sampled on the rising edge of clk).
// - While rst=1 at a clock edge, all of the following are cleared:
//   out_valid=0, alu_out=0, all flags=0, acc_out=0.
// - Handshake:
//   - in_ready = !out_valid || out_ready (combinational).
//   - Accept occurs when in_valid && in_ready.
//   - Output transfer occurs when out_valid && out_ready.
// - Latency: an input accepted at edge k produces out_valid=1 after edge k, with its result.
// - out_valid update at each edge (no reset):
//   - set to 1 on accept;
//   - else cleared to 0 on transfer;
//   - else held.
// - Outputs are stable while out_valid && !out_ready: alu_out and all flags do not change.
// - Simultaneous transfer and accept in one cycle: the new result replaces the old one;
//   out_valid stays 1. Full throughput, no bubble.
// - Opcodes. All arithmetic is modulo 2^WIDTH; internal sum is WIDTH+1 bits.
//   - 000 CLR:  result=0; acc<=0.
//   - 001 ADD:  result=A+B; C = carry-out.
//   - 010 SUB:  result=A-B; C = (A<B) unsigned borrow.
//   - 011 AND:  result=A&B.
//   - 100 OR:   result=A|B.
//   - 101 NOTA: result=~A.
//   - 110 NOTB: result=~B.
//   - 111 ACC:  result=acc+A; acc<=result; C = carry-out.
// - Flags:
//   - V is signed overflow, for ADD/ACC/SUB only.
//   - C=0 and V=0 for all logic ops and for CLR.
//   - Z and N are derived from the result for every op.
// - Accumulator:
//   - Changes only on an accepted CLR or ACC.
//   - Other ops leave acc unchanged.
//   - acc_out always shows the register value.
// - Reset during a stalled output: the result is discarded; everything is cleared as above.
// TESTING
// - Run all scenarios with WIDTH=8.
// - ADD 0xFF+0x01 -> alu_out=0x00, C=1, Z=1, N=0, V=0.
// - ADD 0x7F+0x01 -> alu_out=0x80, V=1, N=1, C=0.
// - SUB 0x03-0x05 -> alu_out=0xFE, C=1, N=1.
// - SUB 0x80-0x01 -> alu_out=0x7F, V=1.
// - ACC sequence, starting from acc=0:
//   - ACC A=0x10, then ACC A=0xF5 -> results 0x10, then 0x05 with C=1; acc_out=0x05.
//   - Then CLR -> acc_out=0x00, Z=1.
// - Backpressure:
//   - Issue AND then OR back to back, holding out_ready=0 for 3 cycles.
//   - Expect in_ready=0 and the AND result held steady while stalled.
//   - On release, expect both results in order with no loss.
// - Throughput: in_valid=1 and out_ready=1 for 8 ops -> one result per cycle, latency 1.
// - Reset mid-stall: assert rst with out_valid=1 and out_ready=0.
//   -> Next cycle out_valid=0, acc_out=0, in_ready=1.

Source files
------------

// File: rtl/alu_pipe_acc.sv
// Registered WIDTH-bit ALU with status flags, an internal accumulator and
// valid/ready handshakes on both the input and the output side.
module alu_pipe_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic [WIDTH-1:0] acc_out
);

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_NOTB = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  logic             out_valid_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH:0]   acc_sum;
  logic             accept;
  logic             transfer;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_q && out_ready;

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_dif = {1'b0, A} - {1'b0, B};
  assign acc_sum = {1'b0, acc_q} + {1'b0, A};

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    acc_d = acc_q;
    case (op)
      OP_CLR: acc_d = '0;
      OP_ADD: begin
        res_d = add_sum[WIDTH-1:0];
        c_d   = add_sum[WIDTH];
        v_d   = (A[WIDTH-1] == B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
      end
      // Bit WIDTH of the widened difference is the unsigned borrow (A < B).
      OP_SUB: begin
        res_d = sub_dif[WIDTH-1:0];
        c_d   = sub_dif[WIDTH];
        v_d   = (A[WIDTH-1] != B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_NOTA: res_d = ~A;
      OP_NOTB: res_d = ~B;
      OP_ACC: begin
        res_d = acc_sum[WIDTH-1:0];
        c_d   = acc_sum[WIDTH];
        v_d   = (acc_q[WIDTH-1] == A[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
        acc_d = acc_sum[WIDTH-1:0];
      end
      default: res_d = '0;
    endcase
    z_d = (res_d == '0);
    n_d = res_d[WIDTH-1];
  end

  // Result registers load only on accept, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      acc_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
      c_q         <= c_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
    end else if (transfer) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = res_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Bench for alu_pipe_acc (WIDTH=8): directed corner cases plus random traffic
// checked against an integer-arithmetic reference model.
module tb_alu_pipe_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       flag_c, flag_z, flag_n, flag_v;
  logic [7:0] acc_out;

  int checks = 0;
  int errors = 0;

  // Model state: output-valid, expected {result, C, Z, N, V}, accumulator.
  logic        m_ov;
  logic [11:0] m_cur;
  logic [7:0]  m_acc;

  alu_pipe_acc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .acc_out(acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic logic [11:0] ref_op(input int opc, input int a, input int b, input int acc);
    int r, s, ss;
    logic c, v;
    r = 0; c = 1'b0; v = 1'b0;
    case (opc)
      1: begin s = a + b; r = s % 256; c = (s >= 256);
               ss = to_signed8(a) + to_signed8(b); v = (ss > 127) || (ss < -128); end
      2: begin s = a - b; r = (s + 256) % 256; c = (a < b);
               ss = to_signed8(a) - to_signed8(b); v = (ss > 127) || (ss < -128); end
      3: r = a & b;
      4: r = a | b;
      5: r = 255 - a;
      6: r = 255 - b;
      7: begin s = acc + a; r = s % 256; c = (s >= 256);
               ss = to_signed8(acc) + to_signed8(a); v = (ss > 127) || (ss < -128); end
      default: r = 0;
    endcase
    return {r[7:0], c, (r == 0), r[7], v};
  endfunction

  function automatic logic [11:0] dut_out();
    return {alu_out, flag_c, flag_z, flag_n, flag_v};
  endfunction

  // One clock cycle with the inputs currently driven; model advances alongside.
  task automatic tick();
    logic        acc_ok, xfer;
    logic [11:0] r;
    int          opc;
    #2;
    chk("in_ready", in_ready, !m_ov || out_ready);
    if (m_ov) chk("out_held", dut_out(), m_cur);
    acc_ok = in_valid && (!m_ov || out_ready);
    xfer   = m_ov && out_ready;
    opc    = int'(op);
    r      = ref_op(opc, int'(A), int'(B), int'(m_acc));
    @(posedge clk); #1;
    if (acc_ok) begin
      m_cur = r;
      m_ov  = 1'b1;
      if (opc == 0) m_acc = 8'h00;
      else if (opc == 7) m_acc = r[11:4];
    end else if (xfer) begin
      m_ov = 1'b0;
    end
    chk("out_valid", out_valid, m_ov);
    chk("acc_out", acc_out, m_acc);
    if (m_ov) chk("out_new", dut_out(), m_cur);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ov = 1'b0; m_acc = 8'h00; m_cur = 12'h000;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_out", dut_out(), 12'h000);
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; A = a; B = b; in_valid = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = 8'h00; B = 8'h00; op = 3'b000;
    m_ov = 1'b0; m_acc = 8'h00; m_cur = 12'h000;
    do_reset();

    out_ready = 1'b1;
    issue(3'b001, 8'hFF, 8'h01);
    chk("add_ff01_res", alu_out, 8'h00);
    chk("add_ff01_czsv", {flag_c, flag_z, flag_n, flag_v}, 4'b1100);
    issue(3'b001, 8'h7F, 8'h01);
    chk("add_7f01_res", alu_out, 8'h80);
    chk("add_7f01_czsv", {flag_c, flag_z, flag_n, flag_v}, 4'b0011);
    issue(3'b010, 8'h03, 8'h05);
    chk("sub_0305_res", alu_out, 8'hFE);
    chk("sub_0305_cn", {flag_c, flag_n}, 2'b11);
    issue(3'b010, 8'h80, 8'h01);
    chk("sub_8001_res", alu_out, 8'h7F);
    chk("sub_8001_v", flag_v, 1'b1);

    do_reset();
    issue(3'b111, 8'h10, 8'h00);
    chk("acc1_res", alu_out, 8'h10);
    issue(3'b111, 8'hF5, 8'h00);
    chk("acc2_res", alu_out, 8'h05);
    chk("acc2_c", flag_c, 1'b1);
    chk("acc2_acc", acc_out, 8'h05);
    issue(3'b000, 8'h00, 8'h00);
    chk("clr_acc", acc_out, 8'h00);
    chk("clr_z", flag_z, 1'b1);

    // Drain, then AND/OR back to back with the consumer stalled.
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    issue(3'b011, 8'hCC, 8'hAA);
    op = 3'b100; A = 8'hCC; B = 8'hAA; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_and_held", alu_out, 8'h88);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_or_res", alu_out, 8'hEE);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 1'b0);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(1, 6)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      chk("tput_valid", out_valid, 1'b1);
    end

    in_valid = 1'b1; op = 3'b001; A = 8'h12; B = 8'h34; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    do_reset();
    #2;
    chk("rst_stall_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      A  = 8'($urandom_range(0, 255));
      B  = 8'($urandom_range(0, 255));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
